bcd_adjust: RTL and testbench

Decimal-mode correction stage directly downstream of the ALU adder. When the core executes ADC/SBC with the D flag set, the binary sum, carry and overflow from the ALU are captured here and corrected to packed BCD over two extra cycles. The control FSM holds off the register-file write until `done`, then writes `DO` and the flags. In binary mode this block is not started.

---
 rtl/bcd_adjust.sv | 163 ++++++++++++++++
 tb/tb_bcd_adjust.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_adjust.sv
// Packed-BCD correction stage behind the ALU adder: captures the binary ADC/SBC
// result, applies the low/high nibble fix-ups over two cycles, then pulses done.
module bcd_adjust (
   input  logic       clk,
   input  logic       RST,
   input  logic       start,
   input  logic       sub,
   input  logic [7:0] A,
   input  logic [7:0] M,
   input  logic [7:0] BIN,
   input  logic       BC,
   input  logic       BV,
   output logic       busy,
   output logic       done,
   output logic [7:0] DO,
   output logic       CO,
   output logic       ZO,
   output logic       NO,
   output logic       VO
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2
   } state_t;

   state_t     state_q, state_d;

   // capture / working registers (no reset needed, only read after a capture)
   logic [7:0] s_q, s_d;
   logic [7:0] bin0_q, bin0_d;
   logic       c0_q, c0_d;
   logic       lc_q, lc_d;
   logic       h_q, h_d;
   logic       sb_q, sb_d;
   logic       vsh_q, vsh_d;

   // visible results
   logic [7:0] do_q, do_d;
   logic       co_q, co_d;
   logic       vo_q, vo_d;
   logic       done_q, done_d;

   logic       mx4;
   logic [8:0] lo_sum;

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:  state_d = start ? S_LO : S_IDLE;
         S_LO:    state_d = S_HI;
         S_HI:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
   end

   always_comb begin
      s_d    = s_q;
      bin0_d = bin0_q;
      c0_d   = c0_q;
      lc_d   = lc_q;
      h_d    = h_q;
      sb_d   = sb_q;
      vsh_d  = vsh_q;
      do_d   = do_q;
      co_d   = co_q;
      vo_d   = vo_q;
      done_d = 1'b0;

      // bit 4 of the operand actually presented to the adder, to recover the nibble carry
      mx4    = sub ? ~M[4] : M[4];
      lo_sum = {1'b0, s_q} + 9'd6;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               s_d    = BIN;
               bin0_d = BIN;
               c0_d   = BC;
               lc_d   = 1'b0;
               sb_d   = sub;
               vsh_d  = BV;
               h_d    = A[4] ^ mx4 ^ BIN[4];
            end
         end
         S_LO: begin
            if (!sb_q) begin
               if (h_q || (s_q[3:0] > 4'd9)) begin
                  s_d  = lo_sum[7:0];
                  lc_d = lo_sum[8];
               end
            end else if (!h_q) begin
               s_d = s_q - 8'd6;
            end
         end
         S_HI: begin
            done_d = 1'b1;
            vo_d   = vsh_q;
            if (!sb_q) begin
               // high fix-up keys off the original carry, not the one from the low fix-up
               if (c0_q || (bin0_q > 8'h99)) begin
                  do_d = s_q + 8'h60;
                  co_d = 1'b1;
               end else begin
                  do_d = s_q;
                  co_d = c0_q | lc_q;
               end
            end else begin
               do_d = c0_q ? s_q : (s_q - 8'h60);
               co_d = c0_q;
            end
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      s_q    <= s_d;
      bin0_q <= bin0_d;
      c0_q   <= c0_d;
      lc_q   <= lc_d;
      h_q    <= h_d;
      sb_q   <= sb_d;
      vsh_q  <= vsh_d;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         do_q   <= 8'h00;
         co_q   <= 1'b0;
         vo_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         do_q   <= do_d;
         co_q   <= co_d;
         vo_q   <= vo_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;
   assign DO   = do_q;
   assign CO   = co_q;
   assign VO   = vo_q;
   assign ZO   = (do_q == 8'h00);
   assign NO   = do_q[7];

endmodule

// File: tb/tb_bcd_adjust.sv
// Bench for bcd_adjust: plays the ALU, and checks results against decimal arithmetic
// on the operands plus the start/done/reset handshake.
module tb_bcd_adjust;

   logic       clk = 1'b0;
   logic       RST, start, sub, BC, BV;
   logic [7:0] A, M, BIN;
   logic       busy, done, CO, ZO, NO, VO;
   logic [7:0] DO;

   int n_cmp = 0;
   int n_err = 0;

   bcd_adjust dut (
      .clk(clk), .RST(RST), .start(start), .sub(sub),
      .A(A), .M(M), .BIN(BIN), .BC(BC), .BV(BV),
      .busy(busy), .done(done), .DO(DO), .CO(CO), .ZO(ZO), .NO(NO), .VO(VO)
   );

   always #5 clk = ~clk;

   // binary adder the block sits behind
   function automatic void alu_model(input logic [7:0] a, input logic [7:0] m, input logic cin,
                                     input logic sb, output logic [7:0] bin, output logic bc,
                                     output logic bv);
      logic [7:0] mx;
      logic [8:0] t;
      mx  = sb ? ~m : m;
      t   = {1'b0, a} + {1'b0, mx} + {8'd0, cin};
      bin = t[7:0];
      bc  = t[8];
      bv  = ~(a[7] ^ mx[7]) & (a[7] ^ bin[7]);
   endfunction

   // decimal meaning of the operation on packed-BCD operands
   function automatic void dec_model(input logic [7:0] a, input logic [7:0] m, input logic cin,
                                     input logic sb, output logic [7:0] d, output logic co);
      int x, y, r;
      x = int'(a[7:4]) * 10 + int'(a[3:0]);
      y = int'(m[7:4]) * 10 + int'(m[3:0]);
      if (!sb) begin
         r  = x + y + int'(cin);
         co = (r >= 100);
         r  = r % 100;
      end else begin
         r  = x - y - (cin ? 0 : 1);
         co = (r >= 0);
         if (r < 0) r = r + 100;
      end
      d[7:4] = 4'(r / 10);
      d[3:0] = 4'(r % 10);
   endfunction

   function automatic logic [7:0] rand_bcd();
      logic [7:0] v;
      v[7:4] = 4'($urandom_range(9));
      v[3:0] = 4'($urandom_range(9));
      return v;
   endfunction

   task automatic drive_op(input logic [7:0] a, input logic [7:0] m, input logic cin,
                           input logic sb);
      logic [7:0] bin;
      logic       bc, bv;
      alu_model(a, m, cin, sb, bin, bc, bv);
      A = a; M = m; sub = sb; BIN = bin; BC = bc; BV = bv;
      start = 1'b1;
   endtask

   // called at a negedge; returns the cycle count to done, or -1 if it never came
   task automatic run_op(input logic [7:0] a, input logic [7:0] m, input logic cin,
                         input logic sb, output int lat);
      drive_op(a, m, cin, sb);
      lat = -1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; start = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (DO !== 8'h00) begin n_err++; $display("FAIL reset_do: got %h want 00", DO); end
      n_cmp++; if ({CO, VO, ZO, NO} !== 4'b0010) begin n_err++; $display("FAIL reset_flags: got CVZN=%b want 0010", {CO, VO, ZO, NO}); end
      RST = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [7:0] ta [6] = '{8'h45, 8'h99, 8'h99, 8'h58, 8'h42, 8'h10};
      logic [7:0] tm [6] = '{8'h38, 8'h01, 8'h99, 8'h46, 8'h13, 8'h20};
      logic       tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic       ts [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] ed [6] = '{8'h83, 8'h00, 8'h98, 8'h05, 8'h29, 8'h90};
      logic       ec [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       ev [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 6; i++) begin
         run_op(ta[i], tm[i], tc[i], ts[i], lat);
         n_cmp++; if (lat != 3) begin n_err++; $display("FAIL dir%0d_latency: got %0d want 3", i, lat); end
         n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_at_done: got %b want 0", i, busy); end
         n_cmp++; if (DO !== ed[i]) begin n_err++; $display("FAIL dir%0d_do: got %h want %h", i, DO, ed[i]); end
         n_cmp++; if (CO !== ec[i]) begin n_err++; $display("FAIL dir%0d_co: got %b want %b", i, CO, ec[i]); end
         n_cmp++; if (VO !== ev[i]) begin n_err++; $display("FAIL dir%0d_vo: got %b want %b", i, VO, ev[i]); end
         n_cmp++; if ({ZO, NO} !== {ed[i] == 8'h00, ed[i][7]}) begin
            n_err++; $display("FAIL dir%0d_zn: got %b%b want %b%b", i, ZO, NO, ed[i] == 8'h00, ed[i][7]);
         end
         @(negedge clk);
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_width: got %b want 0", i, done); end
      end
   endtask

   task automatic test_random();
      logic [7:0] a, m, bin, ed;
      logic       cin, sb, bc, bv, ec;
      int lat;
      for (int i = 0; i < 40; i++) begin
         a = rand_bcd(); m = rand_bcd();
         cin = 1'($urandom_range(1)); sb = 1'($urandom_range(1));
         alu_model(a, m, cin, sb, bin, bc, bv);
         dec_model(a, m, cin, sb, ed, ec);
         run_op(a, m, cin, sb, lat);
         n_cmp++; if (lat != 3) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want 3", i, lat); end
         n_cmp++; if ({DO, CO, VO} !== {ed, ec, bv}) begin
            n_err++; $display("FAIL rnd%0d_result (%h %s %h c%b): got %h C%b V%b want %h C%b V%b",
                              i, a, sb ? "-" : "+", m, cin, DO, CO, VO, ed, ec, bv);
         end
         n_cmp++; if ({ZO, NO} !== {ed == 8'h00, ed[7]}) begin
            n_err++; $display("FAIL rnd%0d_zn: got %b%b want %b%b", i, ZO, NO, ed == 8'h00, ed[7]);
         end
      end
   endtask

   task automatic test_start_ignored();
      logic [7:0] ed;
      logic       ec;
      int ndone = 0;
      dec_model(8'h27, 8'h15, 1'b0, 1'b0, ed, ec);
      drive_op(8'h27, 8'h15, 1'b0, 1'b0);
      @(negedge clk);
      drive_op(8'h50, 8'h50, 1'b1, 1'b0);
      @(negedge clk);
      drive_op(8'h11, 8'h88, 1'b1, 1'b1);
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) ndone++;
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ign_done_on_time: got %b want 1", done); end
      n_cmp++; if (DO !== ed) begin n_err++; $display("FAIL ign_do: got %h want %h", DO, ed); end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", ndone); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] qa [4], qm [4], ed [4], bin;
      logic       qc [4], qs [4], ec [4], ev [4], bc;
      for (int i = 0; i < 4; i++) begin
         qa[i] = rand_bcd(); qm[i] = rand_bcd();
         qc[i] = 1'($urandom_range(1)); qs[i] = 1'($urandom_range(1));
         dec_model(qa[i], qm[i], qc[i], qs[i], ed[i], ec[i]);
         alu_model(qa[i], qm[i], qc[i], qs[i], bin, bc, ev[i]);
      end
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) begin
            if (k % 3 == 0) begin
               n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done_k%0d: got %b want 1", k, done); end
               n_cmp++; if ({DO, CO, VO} !== {ed[k/3-1], ec[k/3-1], ev[k/3-1]}) begin
                  n_err++; $display("FAIL b2b_result_k%0d: got %h C%b V%b want %h C%b V%b",
                                    k, DO, CO, VO, ed[k/3-1], ec[k/3-1], ev[k/3-1]);
               end
            end else begin
               n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_idle_k%0d: got %b want 0", k, done); end
            end
         end
         if (k % 3 == 0 && k < 12) drive_op(qa[k/3], qm[k/3], qc[k/3], qs[k/3]);
         else if (k == 12) start = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_vo_shadow();
      int lat;
      run_op(8'h99, 8'h99, 1'b0, 1'b0, lat);
      n_cmp++; if (VO !== 1'b1) begin n_err++; $display("FAIL vo_set: got %b want 1", VO); end
      drive_op(8'h45, 8'h38, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (VO !== 1'b1) begin n_err++; $display("FAIL vo_held_during_op: got %b want 1", VO); end
      repeat (2) @(negedge clk);
      n_cmp++; if ({done, VO, DO} !== {1'b1, 1'b0, 8'h83}) begin
         n_err++; $display("FAIL vo_update: got done%b V%b %h want done1 V0 83", done, VO, DO);
      end
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      drive_op(8'h66, 8'h77, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      RST = 1'b1;
      @(negedge clk);
      RST = 1'b0;
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL rstmid_ctrl: got busy%b done%b want 00", busy, done); end
      n_cmp++; if ({DO, CO, VO, ZO, NO} !== {8'h00, 4'b0010}) begin
         n_err++; $display("FAIL rstmid_outputs: got %h CVZN=%b want 00 0010", DO, {CO, VO, ZO, NO});
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d want 0", ndone); end
   endtask

   task automatic test_reset_start();
      int ndone = 0;
      int lat;
      drive_op(8'h12, 8'h34, 1'b0, 1'b0);
      RST = 1'b1;
      @(negedge clk);
      RST = 1'b0; start = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rststart_busy: got %b want 0", busy); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL rststart_no_done: got %0d want 0", ndone); end
      run_op(8'h27, 8'h15, 1'b0, 1'b0, lat);
      n_cmp++; if (lat != 3) begin n_err++; $display("FAIL after_rst_latency: got %0d want 3", lat); end
      n_cmp++; if ({DO, CO} !== {8'h42, 1'b0}) begin n_err++; $display("FAIL after_rst_result: got %h C%b want 42 C0", DO, CO); end
   endtask

   initial begin
      RST = 1'b1; start = 1'b0; sub = 1'b0;
      A = 8'h00; M = 8'h00; BIN = 8'h00; BC = 1'b0; BV = 1'b0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      @(negedge clk);
      test_back_to_back();
      @(negedge clk);
      test_vo_shadow();
      @(negedge clk);
      test_reset_mid();
      test_reset_start();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
